mips_mem_sequencer: RTL and testbench
=====================================

MIPS_MEM_SEQUENCER -- requirements
Module: mips_mem_sequencer

Interface
REQ-001 SHALL have ports: clk in 1, rising-edge clock; reset in 1, synchronous active-high reset.
REQ-002 SHALL have ports: pc in 32, fetch address; halt_req in 1, decoder Halt (pc==0); extra in 1, decoder Extra (three-cycle instr).
REQ-003 SHALL have ports: dec_mem_read in 1, dec_mem_write in 1, dec_byteen in 4, data_addr in 32, data_wdata in 32, from decoder/datapath.
REQ-004 SHALL have Avalon-MM master ports: address out 32, read out 1, write out 1, byteenable out 4, writedata out 32, readdata in 32, waitrequest in 1.
REQ-005 SHALL have outputs: state out 2, decoder state; instr out 32, latched instruction; mem_rdata out 32, latched load data; pc_en out 1, PC advance strobe; active out 1, CPU running; bus_error out 1, timeout flag.

Function
REQ-006 SHALL implement states FETCH=2'b00, EXEC1=2'b01, EXEC2=2'b10, HALT=2'b11, driven on state.
REQ-007 SHALL, in FETCH with halt_req=1, issue no bus access and go to HALT next cycle.
REQ-008 SHALL, in FETCH with halt_req=0, drive read=1, address=pc, byteenable=4'b1111, write=0.
REQ-009 SHALL hold in FETCH while waitrequest=1; on read=1 and waitrequest=0, latch readdata into instr and go to EXEC1.
REQ-010 SHALL, in EXEC1, drive read=dec_mem_read, write=dec_mem_write, address=data_addr, byteenable=dec_byteen, writedata=data_wdata.
REQ-011 SHALL hold in EXEC1 while an access is pending and waitrequest=1, with address/byteenable/writedata stable.
REQ-012 SHALL, on EXEC1 completion (no access, or waitrequest=0): if dec_mem_read latch readdata into mem_rdata; go EXEC2 if extra=1, else FETCH.
REQ-013 SHALL go EXEC2 -> FETCH unconditionally after one cycle, with no bus access.
REQ-014 SHALL pulse pc_en for exactly one cycle on each EXEC1->FETCH or EXEC2->FETCH transition; never otherwise.
REQ-015 SHALL never assert read and write together; if both dec_mem_read and dec_mem_write are 1, write wins and read=0.
REQ-016 SHALL remain in HALT until reset, with read=0, write=0, active=0, pc_en=0.
REQ-017 SHALL keep instr and mem_rdata unchanged except on their latch events.
REQ-018 SHALL register state, instr, mem_rdata, pc_en, active, bus_error; bus outputs are combinational from state and inputs.

Reset
REQ-019 SHALL on reset=1 at a clock edge set state=FETCH, instr=0, mem_rdata=0, pc_en=0, active=1, bus_error=0.
REQ-020 SHALL, when reset asserts mid-access, abandon the access: read/write follow FETCH rules from the next cycle, no data latched.
REQ-021 SHALL let reset take priority over every other transition, including from HALT.

Configuration
REQ-022 SHALL, with MIPS_SEQ_TIMEOUT_EN defined, count consecutive cycles with (read|write)=1 and waitrequest=1; on reaching 256 go HALT and set bus_error=1 (sticky until reset).
REQ-023 SHALL reset the timeout counter on any cycle without a stalled access and on reset.
REQ-024 SHALL, without MIPS_SEQ_TIMEOUT_EN, wait indefinitely on waitrequest and tie bus_error to 0.

Structure
REQ-025 SHALL take state encodings (enum) and TIMEOUT_CYCLES=256 from shared package mips_pkg, also used by mips_decoder.
REQ-026 SHALL place the timeout counter in sub-module mips_bus_watchdog, instantiated only under MIPS_SEQ_TIMEOUT_EN.

Verification
REQ-027 SHALL cover: reset, pc=0x00000004, readdata=0x24020005, waitrequest=0 -> FETCH,EXEC1,FETCH; instr=0x24020005; pc_en one pulse in cycle 3.
REQ-028 SHALL cover: load, extra=1, waitrequest high 3 cycles in EXEC1, readdata=0xDEADBEEF -> address stable 4 cycles, mem_rdata=0xDEADBEEF, EXEC2 then FETCH.
REQ-029 SHALL cover: store dec_mem_write=1, data_addr=0x100, data_wdata=0x12345678, byteen=4'b0011 -> write=1 one cycle, read=0, FETCH next.
REQ-030 SHALL cover: halt_req=1 in FETCH -> HALT next cycle, active=0, no read; stays 20 cycles until reset.
REQ-031 SHALL cover: reset during EXEC1 with waitrequest=1 -> next cycle state=FETCH, write=0, mem_rdata=0.
REQ-032 SHALL cover, with MIPS_SEQ_TIMEOUT_EN: waitrequest stuck 1 in FETCH -> state=HALT, bus_error=1 after 256 stall cycles; none at 255.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS core control blocks (sequencer and decoder):
// the four-state sequencer encoding and the bus watchdog limit.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_FETCH = 2'b00,
    ST_EXEC1 = 2'b01,
    ST_EXEC2 = 2'b10,
    ST_HALT  = 2'b11
  } seq_state_e;

  // Number of consecutive stalled bus cycles that is treated as a dead bus.
  localparam int TIMEOUT_CYCLES = 256;
  localparam int TIMEOUT_CNT_W  = $clog2(TIMEOUT_CYCLES);

endpackage

// File: rtl/mips_bus_watchdog.sv
// Bus watchdog: counts consecutive cycles in which an access is outstanding
// and waitrequest is high. timeout is asserted combinationally during the
// TIMEOUT_CYCLES-th consecutive stalled cycle so the sequencer can leave at
// that clock edge. Only instantiated when MIPS_SEQ_TIMEOUT_EN is defined.
module mips_bus_watchdog
  import mips_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic stall,
  output logic timeout
);

  logic [TIMEOUT_CNT_W-1:0] cnt;

  assign timeout = stall && (cnt == TIMEOUT_CNT_W'(TIMEOUT_CYCLES - 1));

  // Count stalled cycles; any non-stalled cycle or reset clears the count.
  always_ff @(posedge clk) begin
    if (reset || !stall) begin
      cnt <= '0;
    end else if (!timeout) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/mips_mem_sequencer.sv
// MIPS memory sequencer: steps FETCH -> EXEC1 -> (EXEC2) -> FETCH, owns the
// Avalon-MM master port, latches the fetched instruction and load data, and
// strobes pc_en once per completed instruction. halt_req in FETCH parks the
// core in HALT until reset.
// Optional build macro: MIPS_SEQ_TIMEOUT_EN adds a bus watchdog that halts
// the core and raises a sticky bus_error after a stuck waitrequest.
//
// Bus handshake: a transfer is presented when read or write is 1 and
// completes in the cycle where waitrequest is 0; while waitrequest is 1 the
// master holds address, byteenable and writedata stable. read and write are
// never 1 together.
module mips_mem_sequencer
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        halt_req,
  input  logic        extra,
  input  logic        dec_mem_read,
  input  logic        dec_mem_write,
  input  logic [3:0]  dec_byteen,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic [31:0] address,
  output logic        read,
  output logic        write,
  output logic [3:0]  byteenable,
  output logic [31:0] writedata,
  input  logic [31:0] readdata,
  input  logic        waitrequest,
  output logic [1:0]  state,
  output logic [31:0] instr,
  output logic [31:0] mem_rdata,
  output logic        pc_en,
  output logic        active,
  output logic        bus_error
);

  localparam logic [1:0] FETCH = ST_FETCH;
  localparam logic [1:0] EXEC1 = ST_EXEC1;
  localparam logic [1:0] EXEC2 = ST_EXEC2;
  localparam logic [1:0] HALT  = ST_HALT;

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       stall;
  logic       timeout;
  logic       pc_en_d;
  logic       instr_ld;
  logic       mrd_ld;

  assign state = state_q;

  // Bus outputs decoded from the current state and decoder/datapath inputs.
  always_comb begin
    read       = 1'b0;
    write      = 1'b0;
    address    = '0;
    byteenable = '0;
    writedata  = '0;
    case (state_q)
      FETCH: begin
        address    = pc;
        byteenable = 4'b1111;
        read       = !halt_req;
      end
      EXEC1: begin
        address    = data_addr;
        byteenable = dec_byteen;
        writedata  = data_wdata;
        write      = dec_mem_write;
        read       = dec_mem_read && !dec_mem_write;
      end
      default: ;
    endcase
  end

  assign stall    = (read || write) && waitrequest;
  assign instr_ld = (state_q == FETCH) && read && !waitrequest;
  assign mrd_ld   = (state_q == EXEC1) && read && !waitrequest;

  // Next state; a watchdog timeout overrides any other move.
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH: begin
        if (halt_req)          state_d = HALT;
        else if (!waitrequest) state_d = EXEC1;
      end
      EXEC1: begin
        if (!stall) state_d = extra ? EXEC2 : FETCH;
      end
      EXEC2:   state_d = FETCH;
      default: state_d = HALT;
    endcase
    if (timeout) state_d = HALT;
  end

  // PC advances only when an instruction finishes and control returns to FETCH.
  assign pc_en_d = (state_d == FETCH) && ((state_q == EXEC1) || (state_q == EXEC2));

`ifdef MIPS_SEQ_TIMEOUT_EN
  mips_bus_watchdog u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .stall   (stall),
    .timeout (timeout)
  );
`else
  assign timeout = 1'b0;
`endif

  // Sequencer state and latched results; reset abandons any access in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      instr     <= '0;
      mem_rdata <= '0;
      pc_en     <= 1'b0;
      active    <= 1'b1;
      bus_error <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_en   <= pc_en_d;
      active  <= (state_d != HALT);
      if (timeout)  bus_error <= 1'b1;
      if (instr_ld) instr     <= readdata;
      if (mrd_ld)   mem_rdata <= readdata;
    end
  end

endmodule

// File: tb/tb_mips_mem_sequencer.sv
// Testbench for mips_mem_sequencer: directed scenarios followed by random
// stimulus, all checked against a cycle-level behavioural model. Define
// MIPS_SEQ_TIMEOUT_EN on both RTL and bench to exercise the watchdog.
module tb_mips_mem_sequencer;

  localparam logic [1:0] S_FETCH = 2'b00;
  localparam logic [1:0] S_EXEC1 = 2'b01;
  localparam logic [1:0] S_EXEC2 = 2'b10;
  localparam logic [1:0] S_HALT  = 2'b11;

  // ---------------- clock / reset ----------------
  logic clk;
  logic reset;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [31:0] pc, data_addr, data_wdata, readdata;
  logic        halt_req, extra, dec_mem_read, dec_mem_write, waitrequest;
  logic [3:0]  dec_byteen;
  logic [31:0] address, writedata, instr, mem_rdata;
  logic        read, write, pc_en, active, bus_error;
  logic [3:0]  byteenable;
  logic [1:0]  state;

  mips_mem_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .pc            (pc),
    .halt_req      (halt_req),
    .extra         (extra),
    .dec_mem_read  (dec_mem_read),
    .dec_mem_write (dec_mem_write),
    .dec_byteen    (dec_byteen),
    .data_addr     (data_addr),
    .data_wdata    (data_wdata),
    .address       (address),
    .read          (read),
    .write         (write),
    .byteenable    (byteenable),
    .writedata     (writedata),
    .readdata      (readdata),
    .waitrequest   (waitrequest),
    .state         (state),
    .instr         (instr),
    .mem_rdata     (mem_rdata),
    .pc_en         (pc_en),
    .active        (active),
    .bus_error     (bus_error)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [64:0] exp_q[$];  // {is_write, address, write data}

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [1:0]  m_state;
  logic [31:0] m_instr, m_mrd;
  logic        m_pc_en, m_active, m_berr;
  int          m_stall_cnt;

  task automatic model_reset();
    m_state = S_FETCH; m_instr = 0; m_mrd = 0;
    m_pc_en = 0; m_active = 1; m_berr = 0; m_stall_cnt = 0;
  endtask

  // One clock: check outputs against the model, then advance the model.
  // Called at a negedge with inputs already driven.
  task automatic cycle();
    logic        e_rd, e_wr, acc, done, to;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [64:0] t;
    #1;
    e_rd = 0; e_wr = 0; e_addr = 0; e_be = 0;
    if (m_state == S_FETCH && !halt_req) begin
      e_rd = 1; e_addr = pc; e_be = 4'hF;
    end else if (m_state == S_EXEC1) begin
      e_wr = dec_mem_write;
      e_rd = dec_mem_read && !dec_mem_write;
      e_addr = data_addr; e_be = dec_byteen;
    end
    acc  = e_rd || e_wr;
    done = acc && !waitrequest;

    check("state", 32'(state), 32'(m_state));
    check("instr", instr, m_instr);
    check("mem_rdata", mem_rdata, m_mrd);
    check("pc_en", 32'(pc_en), 32'(m_pc_en));
    check("active", 32'(active), 32'(m_active));
    check("bus_error", 32'(bus_error), 32'(m_berr));
    check("read", 32'(read), 32'(e_rd));
    check("write", 32'(write), 32'(e_wr));
    check("rd_and_wr", 32'(read && write), 32'(0));
    if (acc) begin
      check("address", address, e_addr);
      check("byteenable", 32'(byteenable), 32'(e_be));
    end
    if (e_wr) check("writedata", writedata, data_wdata);

    if (done) exp_q.push_back({e_wr, e_addr, e_wr ? data_wdata : 32'h0});
    if ((read || write) && !waitrequest) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected", 32'(1), 32'(0));
      end else begin
        t = exp_q.pop_front();
        check("sb_we", 32'(write), 32'(t[64]));
        check("sb_addr", address, t[63:32]);
        check("sb_data", write ? writedata : 32'h0, t[31:0]);
      end
    end

    @(posedge clk);
    if (reset) begin
      model_reset();
    end else begin
      to = 0;
`ifdef MIPS_SEQ_TIMEOUT_EN
      if (acc && waitrequest) m_stall_cnt++;
      else m_stall_cnt = 0;
      if (m_stall_cnt >= 256) to = 1;
`endif
      m_pc_en = 0;
      case (m_state)
        S_FETCH: begin
          if (halt_req) m_state = S_HALT;
          else if (done) begin m_instr = readdata; m_state = S_EXEC1; end
        end
        S_EXEC1: begin
          if (!acc || done) begin
            if (e_rd) m_mrd = readdata;
            if (extra) m_state = S_EXEC2;
            else begin m_state = S_FETCH; m_pc_en = 1; end
          end
        end
        S_EXEC2: begin m_state = S_FETCH; m_pc_en = 1; end
        default: m_state = S_HALT;
      endcase
      if (to) begin
        m_state = S_HALT; m_berr = 1; m_pc_en = 0; m_stall_cnt = 0;
      end
      m_active = (m_state != S_HALT);
    end
    @(negedge clk);
  endtask

  // ---------------- drivers ----------------
  task automatic idle_inputs();
    halt_req = 0; extra = 0; dec_mem_read = 0; dec_mem_write = 0;
    dec_byteen = 0; data_addr = 0; data_wdata = 0; waitrequest = 0;
  endtask

  task automatic do_reset();
    reset = 1;
    idle_inputs();
    cycle();
    reset = 0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1; pc = 0; readdata = 0;
    idle_inputs();
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    model_reset();
    do_reset();

    // reset values
    #1;
    check("rst_state", 32'(state), 32'(S_FETCH));
    check("rst_instr", instr, 32'h0);
    check("rst_mrd", mem_rdata, 32'h0);
    check("rst_pc_en", 32'(pc_en), 32'(0));
    check("rst_active", 32'(active), 32'(1));
    check("rst_berr", 32'(bus_error), 32'(0));

    // simple instruction fetch and execute
    pc = 32'h4; readdata = 32'h2402_0005;
    #1;
    check("f_read", 32'(read), 32'(1));
    check("f_addr", address, 32'h4);
    cycle();
    #1;
    check("f_state2", 32'(state), 32'(S_EXEC1));
    check("f_instr", instr, 32'h2402_0005);
    check("f_pc_en2", 32'(pc_en), 32'(0));
    cycle();
    #1;
    check("f_state3", 32'(state), 32'(S_FETCH));
    check("f_pc_en3", 32'(pc_en), 32'(1));
    cycle();
    #1;
    check("f_pc_en4", 32'(pc_en), 32'(0));

    // load with a three-cycle instruction and stalled data access
    do_reset();
    pc = 32'h8; readdata = 32'h8C01_0000;
    cycle();
    dec_mem_read = 1; extra = 1; data_addr = 32'h200; dec_byteen = 4'hF; waitrequest = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("ld_addr_stall", address, 32'h200);
      check("ld_state_stall", 32'(state), 32'(S_EXEC1));
      cycle();
    end
    waitrequest = 0; readdata = 32'hDEAD_BEEF;
    #1;
    check("ld_addr_done", address, 32'h200);
    cycle();
    idle_inputs();
    #1;
    check("ld_state_x2", 32'(state), 32'(S_EXEC2));
    check("ld_mrd", mem_rdata, 32'hDEAD_BEEF);
    check("ld_x2_read", 32'(read), 32'(0));
    cycle();
    #1;
    check("ld_state_f", 32'(state), 32'(S_FETCH));
    check("ld_pc_en", 32'(pc_en), 32'(1));

    // store
    do_reset();
    pc = 32'hC; readdata = 32'hAC00_0100;
    cycle();
    dec_mem_write = 1; data_addr = 32'h100; data_wdata = 32'h1234_5678; dec_byteen = 4'b0011;
    #1;
    check("st_write", 32'(write), 32'(1));
    check("st_read", 32'(read), 32'(0));
    check("st_be", 32'(byteenable), 32'(4'b0011));
    check("st_wdata", writedata, 32'h1234_5678);
    cycle();
    #1;
    check("st_state_f", 32'(state), 32'(S_FETCH));
    check("st_write_off", 32'(write), 32'(0));
    idle_inputs();

    // read and write requested together: write wins
    do_reset();
    cycle();
    dec_mem_read = 1; dec_mem_write = 1; data_addr = 32'h40; data_wdata = 32'h5A5A_0001;
    #1;
    check("rw_write", 32'(write), 32'(1));
    check("rw_read", 32'(read), 32'(0));
    cycle();
    idle_inputs();

    // halt
    do_reset();
    halt_req = 1; pc = 32'h0;
    #1;
    check("h_read", 32'(read), 32'(0));
    cycle();
    for (int i = 0; i < 20; i++) begin
      halt_req = 1'($urandom_range(0, 1));
      #1;
      check("h_state", 32'(state), 32'(S_HALT));
      check("h_active", 32'(active), 32'(0));
      check("h_read", 32'(read), 32'(0));
      check("h_pc_en", 32'(pc_en), 32'(0));
      cycle();
    end
    do_reset();
    #1;
    check("h_exit_state", 32'(state), 32'(S_FETCH));

    // reset in the middle of a stalled store
    pc = 32'h10;
    cycle();
    dec_mem_write = 1; data_addr = 32'h300; waitrequest = 1;
    cycle();
    reset = 1;
    cycle();
    reset = 0;
    #1;
    check("ra_state", 32'(state), 32'(S_FETCH));
    check("ra_write", 32'(write), 32'(0));
    check("ra_mrd", mem_rdata, 32'h0);
    idle_inputs();

`ifdef MIPS_SEQ_TIMEOUT_EN
    // stuck waitrequest during fetch
    do_reset();
    waitrequest = 1; pc = 32'h20;
    for (int i = 0; i < 255; i++) cycle();
    #1;
    check("to_state_255", 32'(state), 32'(S_FETCH));
    check("to_berr_255", 32'(bus_error), 32'(0));
    cycle();
    #1;
    check("to_state_256", 32'(state), 32'(S_HALT));
    check("to_berr_256", 32'(bus_error), 32'(1));
    check("to_active", 32'(active), 32'(0));
    cycle();
    #1;
    check("to_sticky", 32'(bus_error), 32'(1));
    idle_inputs();
`endif

    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset         = ($urandom_range(0, 49) == 0);
      halt_req      = ($urandom_range(0, 39) == 0);
      extra         = 1'($urandom_range(0, 1));
      dec_mem_read  = 1'($urandom_range(0, 1));
      dec_mem_write = ($urandom_range(0, 2) == 0);
      dec_byteen    = 4'($urandom_range(0, 15));
      waitrequest   = ($urandom_range(0, 2) == 0);
      pc            = $urandom;
      data_addr     = $urandom;
      data_wdata    = $urandom;
      readdata      = $urandom;
      cycle();
    end
    reset = 0;
    idle_inputs();

    check("sb_drained", 32'(exp_q.size()), 32'(0));
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
